// File: rtl/riscv_biu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : riscv_biu_arbiter                                             |
// | Purpose  : Shares one BIU command/response channel between the icache    |
// |            (m0) and dcache (m1) hit stages. Round-robin grant with lock  |
// |            and grant-limit awareness; ownership only changes once every  |
// |            outstanding beat has returned, so responses need no tag.      |
// | Ports    : clk_i, rst_i            clock, asynchronous active-high reset |
// |            mX_req/adr/size/lock/we/d/burst_i   master command inputs     |
// |            mX_stb_ack/ack/err/q_o             master handshakes, data    |
// |            biu_req/adr/size/lock/we/d/burst_o command to the BIU         |
// |            biu_stb_ack/ack/err/q_i            BIU handshakes, read data  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module riscv_biu_arbiter #(
  parameter int XLEN           = 32,
  parameter int PLEN           = XLEN,
  parameter int INFLIGHT_DEPTH = 2,
  parameter int BURST_SIZE     = 4,
  parameter int GRANT_LIMIT    = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            m0_req_i,
  input  logic [PLEN-1:0] m0_adr_i,
  input  logic [2:0]      m0_size_i,
  input  logic            m0_lock_i,
  input  logic            m0_we_i,
  input  logic [XLEN-1:0] m0_d_i,
  input  logic            m0_burst_i,
  output logic            m0_stb_ack_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [XLEN-1:0] m0_q_o,

  input  logic            m1_req_i,
  input  logic [PLEN-1:0] m1_adr_i,
  input  logic [2:0]      m1_size_i,
  input  logic            m1_lock_i,
  input  logic            m1_we_i,
  input  logic [XLEN-1:0] m1_d_i,
  input  logic            m1_burst_i,
  output logic            m1_stb_ack_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [XLEN-1:0] m1_q_o,

  output logic            biu_req_o,
  output logic [PLEN-1:0] biu_adr_o,
  output logic [2:0]      biu_size_o,
  output logic            biu_lock_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  output logic            biu_burst_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i,
  input  logic [XLEN-1:0] biu_q_i
);

  localparam int CNT_W  = $clog2(INFLIGHT_DEPTH*BURST_SIZE+1);
  localparam int TXN_W  = $clog2(INFLIGHT_DEPTH+1);
  localparam int GCNT_W = $clog2(GRANT_LIMIT+1);
  localparam int BEAT_W = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
  localparam int PTR_W  = (INFLIGHT_DEPTH > 1) ? $clog2(INFLIGHT_DEPTH) : 1;

  localparam logic [CNT_W-1:0]  C_BURST_BEATS = CNT_W'(BURST_SIZE);
  localparam logic [TXN_W-1:0]  C_TXN_MAX     = TXN_W'(INFLIGHT_DEPTH);
  localparam logic [GCNT_W-1:0] C_GNT_MAX     = GCNT_W'(GRANT_LIMIT);
  localparam logic [BEAT_W-1:0] C_BEAT_LAST   = BEAT_W'(BURST_SIZE-1);
  localparam logic [PTR_W-1:0]  C_PTR_LAST    = PTR_W'(INFLIGHT_DEPTH-1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_q, last_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [TXN_W-1:0]          txn_q, txn_d;
  logic [GCNT_W-1:0]         gnt_cnt_q, gnt_cnt_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  // One bit per accepted transaction: 1 = burst. Responses return in order,
  // so the head entry tells how many beats finish the oldest transaction.
  logic [INFLIGHT_DEPTH-1:0] burst_fifo_q, burst_fifo_d;

  // Owner-selected command
  logic            own_req, own_lock, own_we, own_burst, oth_req;
  logic [PLEN-1:0] own_adr;
  logic [2:0]      own_size;
  logic [XLEN-1:0] own_d;

  logic            in_grant, has_owner, release_gnt;
  logic            accept, beat, last_beat, head_burst;
  logic            cnt_nz;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    own_req   = owner_q ? m1_req_i   : m0_req_i;
    own_adr   = owner_q ? m1_adr_i   : m0_adr_i;
    own_size  = owner_q ? m1_size_i  : m0_size_i;
    own_lock  = owner_q ? m1_lock_i  : m0_lock_i;
    own_we    = owner_q ? m1_we_i    : m0_we_i;
    own_d     = owner_q ? m1_d_i     : m0_d_i;
    own_burst = owner_q ? m1_burst_i : m0_burst_i;
    oth_req   = owner_q ? m0_req_i   : m1_req_i;
  end

  assign in_grant  = (state_q == ST_GRANT);
  assign has_owner = (state_q != ST_IDLE);
  assign cnt_nz    = (cnt_q != '0);

  // Owner gives up the channel when not locked and either idle or it has
  // used up its share while the other master waits.
  assign release_gnt = in_grant & ~own_lock &
                       (~own_req | (oth_req & (gnt_cnt_q == C_GNT_MAX)));

  // Command path: combinational from the owner while granted. The request
  // is withheld in the releasing cycle so no beat is accepted on the way out.
  always_comb begin
    biu_req_o   = in_grant & own_req & ~release_gnt & (txn_q < C_TXN_MAX);
    biu_adr_o   = in_grant ? own_adr   : '0;
    biu_size_o  = in_grant ? own_size  : '0;
    biu_we_o    = in_grant & own_we;
    biu_d_o     = in_grant ? own_d     : '0;
    biu_burst_o = in_grant & own_burst;
    biu_lock_o  = in_grant & own_lock;
  end

  assign accept = biu_req_o & biu_stb_ack_i;
  // Beats arriving with nothing outstanding are protocol violations; drop them.
  assign beat   = (biu_ack_i | biu_err_i) & cnt_nz;

  // Response routing to the current owner only
  always_comb begin
    m0_stb_ack_o = accept & ~owner_q;
    m1_stb_ack_o = accept &  owner_q;
    m0_ack_o     = has_owner & ~owner_q & biu_ack_i & cnt_nz;
    m1_ack_o     = has_owner &  owner_q & biu_ack_i & cnt_nz;
    m0_err_o     = has_owner & ~owner_q & biu_err_i & cnt_nz;
    m1_err_o     = has_owner &  owner_q & biu_err_i & cnt_nz;
    m0_q_o       = has_owner ? biu_q_i : '0;
    m1_q_o       = has_owner ? biu_q_i : '0;
  end

  // Beat / transaction bookkeeping
  assign head_burst = burst_fifo_q[rd_ptr_q];
  assign last_beat  = beat & (~head_burst | (beat_q == C_BEAT_LAST));

  always_comb begin
    cnt_inc      = accept ? (own_burst ? C_BURST_BEATS : CNT_W'(1)) : '0;
    cnt_d        = cnt_q + cnt_inc - CNT_W'(beat);
    txn_d        = txn_q + TXN_W'(accept) - TXN_W'(last_beat);
    beat_d       = beat_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    burst_fifo_d = burst_fifo_q;

    if (last_beat) begin
      beat_d   = '0;
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else if (beat) begin
      beat_d   = beat_q + BEAT_W'(1);
    end

    if (accept) begin
      burst_fifo_d[wr_ptr_q] = own_burst;
      wr_ptr_d               = ptr_inc(wr_ptr_q);
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt_cnt_d = gnt_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (m0_req_i | m1_req_i) begin
          state_d   = ST_GRANT;
          // Tie goes to whoever did not own the channel last.
          owner_d   = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;
          gnt_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (accept && (gnt_cnt_q != C_GNT_MAX)) begin
          gnt_cnt_d = gnt_cnt_q + GCNT_W'(1);
        end
        if (release_gnt) begin
          last_d  = owner_q;
          state_d = (cnt_d == '0) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      txn_q        <= '0;
      gnt_cnt_q    <= '0;
      beat_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      burst_fifo_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      txn_q        <= txn_d;
      gnt_cnt_q    <= gnt_cnt_d;
      beat_q       <= beat_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      burst_fifo_q <= burst_fifo_d;
    end
  end

endmodule
`default_nettype wire
